// File: rtl/instr_fetch.sv
// RV32I instruction fetch: program counter, valid/ready imem request channel and a DEPTH-entry {word, pc} FIFO.
// Optional misaligned-redirect halt is built when FETCH_MISALIGN_CHK_EN is defined.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_misalign
);
    localparam int             PTR_W   = $clog2(DEPTH);
    localparam int             CNT_W   = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = DEPTH[CNT_W:0];

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t           r_state;
    logic [31:0]      r_pc;
    logic [31:0]      r_req_pc;
    logic [31:0]      r_fifo_word [DEPTH];
    logic [31:0]      r_fifo_pc   [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_outstanding;
    logic [CNT_W:0]   w_occupancy;
    logic             w_space;
    logic             w_req_hs;
    logic             w_push;
    logic             w_pop;
    logic             w_halted;
    logic [31:0]      w_redirect_target;

`ifdef FETCH_MISALIGN_CHK_EN
    logic r_halted;
    logic r_fetch_misalign;
    logic w_misaligned;

    assign w_misaligned      = (redirect_pc[1:0] != 2'b00);
    assign w_redirect_target = redirect_pc;

    // Every redirect re-evaluates alignment, so an aligned one releases the halt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_halted         <= 1'b0;
            r_fetch_misalign <= 1'b0;
        end else if (redirect_valid) begin
            r_halted         <= w_misaligned;
            r_fetch_misalign <= w_misaligned;
        end
    end

    assign w_halted       = r_halted;
    assign fetch_misalign = r_fetch_misalign;
`else
    assign w_redirect_target = redirect_pc & 32'hFFFF_FFFC;
    assign w_halted          = 1'b0;
    assign fetch_misalign    = 1'b0;
`endif

    // An in-flight read already owns a FIFO slot; pop credit is deliberately not counted.
    assign w_outstanding = (r_state == S_WAIT) || (r_state == S_DROP);
    assign w_occupancy   = {1'b0, r_count} + {{CNT_W{1'b0}}, w_outstanding};
    assign w_space       = (w_occupancy < DEPTH_C);

    assign imem_req_valid = !redirect_valid && !w_halted && w_space &&
                            ((r_state == S_FETCH) || ((r_state == S_WAIT) && imem_rsp_valid));
    assign imem_req_addr  = r_pc;
    assign w_req_hs       = imem_req_valid && imem_req_ready;

    assign instr_valid = (r_count != '0) && !redirect_valid;
    assign w_pop       = instr_valid && instr_ready;
    assign w_push      = (r_state == S_WAIT) && imem_rsp_valid && !redirect_valid;

    assign instr    = r_fifo_word[r_rd_ptr];
    assign instr_pc = r_fifo_pc[r_rd_ptr];

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_FETCH;
            r_pc     <= RESET_PC;
            r_req_pc <= RESET_PC;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (redirect_valid) begin
            r_pc     <= w_redirect_target;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            case (r_state)
                S_WAIT:  r_state <= imem_rsp_valid ? S_FETCH : S_DROP;
                S_DROP:  r_state <= imem_rsp_valid ? S_FETCH : S_DROP;
                default: r_state <= S_FETCH;
            endcase
        end else begin
            if (w_req_hs) begin
                r_pc     <= r_pc + 32'd4;
                r_req_pc <= r_pc;
            end

            case (r_state)
                S_FETCH: if (w_req_hs) r_state <= S_WAIT;
                S_WAIT:  if (imem_rsp_valid && !w_req_hs) r_state <= S_FETCH;
                S_DROP:  if (imem_rsp_valid) r_state <= S_FETCH;
                default: r_state <= S_FETCH;
            endcase

            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is reset because the head entry is visible on instr/instr_pc straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_word[i] <= 32'h0;
                r_fifo_pc[i]   <= 32'h0;
            end
        end else if (w_push) begin
            r_fifo_word[r_wr_ptr] <= imem_rsp_data;
            r_fifo_pc[r_wr_ptr]   <= r_req_pc;
        end
    end

endmodule
